// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller for a pipelined MIPS core.
// Multiply and divide run for a fixed number of busy cycles. Only the final result is written to HI/LO.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Use_MD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        unsigned_reg;

    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Sign handling is done on magnitudes so that 0x80000000 / -1 wraps cleanly.
    always_comb begin
        ext_a = {{32{~unsigned_reg & a_reg[31]}}, a_reg};
        ext_b = {{32{~unsigned_reg & b_reg[31]}}, b_reg};
        prod  = ext_a * ext_b;

        a_neg = ~unsigned_reg & a_reg[31];
        b_neg = ~unsigned_reg & b_reg[31];
        a_mag = a_neg ? (32'd0 - a_reg) : a_reg;
        b_mag = b_neg ? (32'd0 - b_reg) : b_reg;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    assign Stall = Use_MD & (Busy | Start);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= 5'd0;
            a_reg        <= 32'd0;
            b_reg        <= 32'd0;
            unsigned_reg <= 1'b0;
            HI           <= 32'd0;
            LO           <= 32'd0;
            Busy         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            3'd0, 3'd1: begin
                                a_reg        <= A;
                                b_reg        <= B;
                                unsigned_reg <= MDOp[0];
                                count_reg    <= MULT_N;
                                state_reg    <= MUL;
                                Busy         <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                a_reg        <= A;
                                b_reg        <= B;
                                unsigned_reg <= MDOp[0];
                                count_reg    <= DIV_N;
                                state_reg    <= DIV;
                                Busy         <= 1'b1;
                            end
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (count_reg == 5'd1) begin
                        HI        <= prod[63:32];
                        LO        <= prod[31:0];
                        count_reg <= 5'd0;
                        state_reg <= IDLE;
                        Busy      <= 1'b0;
                    end else begin
                        count_reg <= count_reg - 5'd1;
                    end
                end
                DIV: begin
                    if (count_reg == 5'd1) begin
                        // A zero divisor burns the full period but leaves HI/LO alone.
                        if (b_reg != 32'd0) begin
                            HI <= rem;
                            LO <= quot;
                        end
                        count_reg <= 5'd0;
                        state_reg <= IDLE;
                        Busy      <= 1'b0;
                    end else begin
                        count_reg <= count_reg - 5'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with default cycle counts (5 multiply, 10 divide).
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Use_MD;
    logic [31:0] HI, LO;
    logic        Busy, Stall;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .Use_MD(Use_MD), .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div and walk its busy window, checking HI/LO hold and the final write.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic use_md);
        Use_MD = use_md;
        Start = 1'b1; MDOp = op; A = a; B = b;
        #1;
        check({name, " stall_start"}, {31'd0, Stall}, {31'd0, use_md});
        tick();
        Start = 1'b0; MDOp = 3'd6;
        for (int i = 0; i < n; i++) begin
            #1;
            check({name, " busy"}, {31'd0, Busy}, 32'd1);
            check({name, " hi_hold"}, HI, hi_m);
            check({name, " lo_hold"}, LO, lo_m);
            check({name, " stall_busy"}, {31'd0, Stall}, {31'd0, use_md});
            tick();
        end
        #1;
        check({name, " busy_done"}, {31'd0, Busy}, 32'd0);
        check({name, " hi"}, HI, exp_hi);
        check({name, " lo"}, LO, exp_lo);
        hi_m = exp_hi;
        lo_m = exp_lo;
        $display("txn %s a=%h b=%h -> HI=%h LO=%h", name, a, b, HI, LO);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 3'd6; A = 32'd0; B = 32'd0; Use_MD = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        tick(); tick();
        #2 reset = 1'b1;
        tick();

        run_op("mult",  3'd0, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'h00000003, 5,  32'h00000002, 32'hFFFFFFFA, 1'b0);
        run_op("div",   3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu0", 3'd3, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divovf",3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu",  3'd3, 32'd100,      32'd7,        10, 32'd2,        32'd14,       1'b1);

        // MTHI / MTLO / no-op
        Use_MD = 1'b1; Start = 1'b1; MDOp = 3'd4; A = 32'h00001234;
        #1 check("mthi stall_start", {31'd0, Stall}, 32'd1);
        tick();
        Start = 1'b0; MDOp = 3'd6;
        #1;
        check("mthi hi", HI, 32'h00001234);
        check("mthi lo", LO, 32'd14);
        check("mthi busy", {31'd0, Busy}, 32'd0);
        check("mthi stall_idle", {31'd0, Stall}, 32'd0);
        $display("txn mthi -> HI=%h LO=%h", HI, LO);
        Start = 1'b1; MDOp = 3'd5; A = 32'h00005678;
        tick();
        Start = 1'b0; MDOp = 3'd6;
        #1;
        check("mtlo hi", HI, 32'h00001234);
        check("mtlo lo", LO, 32'h00005678);
        $display("txn mtlo -> HI=%h LO=%h", HI, LO);
        Start = 1'b1; MDOp = 3'd7; A = 32'hDEADBEEF; B = 32'd3;
        tick();
        Start = 1'b0;
        #1;
        check("nop hi", HI, 32'h00001234);
        check("nop lo", LO, 32'h00005678);
        check("nop busy", {31'd0, Busy}, 32'd0);
        $display("txn nop -> HI=%h LO=%h", HI, LO);

        // Second MULT issued during busy cycle 2 must be ignored.
        Use_MD = 1'b1; Start = 1'b1; MDOp = 3'd0; A = 32'd3; B = 32'd4;
        #1 check("stall2 cyc0", {31'd0, Stall}, 32'd1);
        tick();
        Start = 1'b0;
        #1 check("stall2 cyc1", {31'd0, Stall}, 32'd1);
        tick();
        Start = 1'b1; MDOp = 3'd0; A = 32'd100; B = 32'd100;
        #1 check("stall2 cyc2", {31'd0, Stall}, 32'd1);
        tick();
        Start = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            #1 check("stall2 cyc3_5", {31'd0, Stall}, 32'd1);
            check("stall2 hi_hold", HI, 32'h00001234);
            tick();
        end
        #1;
        check("stall2 busy_done", {31'd0, Busy}, 32'd0);
        check("stall2 stall_done", {31'd0, Stall}, 32'd0);
        check("stall2 hi", HI, 32'd0);
        check("stall2 lo", LO, 32'd12);
        $display("txn mult_ignore -> HI=%h LO=%h", HI, LO);

        // Asynchronous reset in busy cycle 3 of a DIV.
        Use_MD = 1'b0; Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        check("arst busy", {31'd0, Busy}, 32'd0);
        check("arst hi", HI, 32'd0);
        check("arst lo", LO, 32'd0);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #1;
        check("arst hi_after", HI, 32'd0);
        check("arst lo_after", LO, 32'd0);
        check("arst busy_after", {31'd0, Busy}, 32'd0);
        $display("txn div_reset -> HI=%h LO=%h", HI, LO);
        hi_m = 32'd0;
        lo_m = 32'd0;

        run_op("multu_post", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set busy duration of MULT/MULTU in cycles (legal range 1..31).
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set busy duration of DIV/DIVU in cycles (legal range 1..31).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Start  input  1  SHALL be the EX-stage issue strobe for an HI/LO instruction, valid for one cycle.
REQ-006 MDOp  input  3  SHALL encode the operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
REQ-007 A  input  32  SHALL be the rs operand (RD1 of EX).
REQ-008 B  input  32  SHALL be the rt operand (RD2 of EX).
REQ-009 Use_MD  input  1  SHALL flag that the D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 HI  output  32  SHALL be the architectural HI register.
REQ-011 LO  output  32  SHALL be the architectural LO register.
REQ-012 Busy  output  1  SHALL indicate a multiply/divide is in progress.
REQ-013 Stall  output  1  SHALL be the pipeline stall request to F/D.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV; a 5-bit down-counter SHALL time MUL/DIV.
REQ-015 In IDLE, Start with MDOp 0/1 SHALL latch A, B and op, load counter with MULT_CYCLES, enter MUL.
REQ-016 In IDLE, Start with MDOp 2/3 SHALL latch A, B and op, load counter with DIV_CYCLES, enter DIV.
REQ-017 Busy SHALL be 1 exactly in MUL/DIV, i.e. for N consecutive cycles beginning the cycle after the Start edge.
REQ-018 At the edge ending the Nth busy cycle, HI/LO SHALL take the result, Busy SHALL fall, FSM SHALL return to IDLE.
REQ-019 HI/LO SHALL hold previous values throughout busy cycles; intermediate results SHALL not be visible.
REQ-020 MULT SHALL form the signed 64-bit product, MULTU the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-021 DIV/DIVU SHALL give LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0x00000000.
REQ-023 Divide by zero (B = 0) SHALL run the full DIV_CYCLES busy period and leave HI/LO unchanged.
REQ-024 In IDLE, Start with MDOp 4 SHALL write HI <= A at that edge (LO unchanged); MDOp 5 SHALL write LO <= A (HI unchanged); Busy stays 0.
REQ-025 Start with MDOp 6/7 SHALL have no effect.
REQ-026 Start while Busy = 1 SHALL be ignored: no state, counter, operand or HI/LO change.
REQ-027 Stall SHALL equal Use_MD & (Busy | Start), combinational, no added latency.
REQ-028 Stall SHALL be 0 whenever Use_MD = 0, regardless of Busy.

Reset
REQ-029 reset = 0 SHALL immediately, without waiting for clk, force HI = 0, LO = 0, Busy = 0, counter = 0, FSM = IDLE.
REQ-030 Reset during MUL/DIV SHALL abort the operation; no HI/LO write SHALL occur after reset releases.
REQ-031 After reset release, the first rising edge with Start = 1 SHALL be accepted normally.

Verification
REQ-032 MULT A=0xFFFFFFFE B=0x00000003 -> Busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFA.
REQ-033 MULTU A=0xFFFFFFFE B=0x00000003 -> after 5 busy cycles HI=0x00000002 LO=0xFFFFFFFA.
REQ-034 DIV A=0xFFFFFFF9 B=0x00000002 -> Busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU A=7 B=0 -> Busy 10 cycles, HI/LO unchanged.
REQ-035 Use_MD=1 held, MULT Start then second MULT Start in busy cycle 2 -> Stall high 6 cycles (Start cycle + 5), second Start ignored, result from first only.
REQ-036 DIV started, reset=0 asynchronously in busy cycle 3 -> Busy, HI, LO = 0 before next edge; no HI/LO update in following 10 cycles.
REQ-037 MTHI A=0x00001234 in IDLE -> HI=0x00001234 after the edge, LO unchanged, Busy 0, Stall follows Use_MD & Start only.
